// File: rtl/multicycle_sequencer.sv
// Control FSM for the multicycle MIPS datapath: fetch, decode, execute,
// memory and writeback steps, with memory-ready handshake, halt at
// instruction boundaries, illegal-opcode flag and retired counter.
module multicycle_sequencer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             pcWriteCond,
  output logic             pcWrite,
  output logic             IorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             memToReg,
  output logic             irWrite,
  output logic [1:0]       pcSource,
  output logic [1:0]       aluOp,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic             regWrite,
  output logic             regDst,
  output logic             illegal_op,
  output logic             halted,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RTYPEWB = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_ADDIEX  = 4'd11,
    S_ADDIWB  = 4'd12,
    S_ILLEGAL = 4'd13,
    S_HALT    = 4'd14
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_retire;
  logic [CNT_W-1:0] r_retired;

  // State register; reset returns to IDLE regardless of any pending access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Retired-instruction counter, bumped when leaving a completing boundary state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + CNT_W'(1);
  end

  // Next-state and control decode; strobes are a function of the current
  // state, with irWrite/pcWrite in FETCH also gated by mem_ready
  always_comb begin
    w_next      = r_state;
    w_retire    = 1'b0;
    pcWriteCond = 1'b0;
    pcWrite     = 1'b0;
    IorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    memToReg    = 1'b0;
    irWrite     = 1'b0;
    pcSource    = 2'b00;
    aluOp       = 2'b00;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    regWrite    = 1'b0;
    regDst      = 1'b0;
    illegal_op  = 1'b0;
    halted      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_next = halt_req ? S_HALT : S_FETCH;
      end
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcA = 1'b1;
        aluSrcB = 2'b01;
        irWrite = mem_ready;
        pcWrite = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        aluSrcB = 2'b10;
        if (opcode == OP_LW)      w_next = S_MEMRD;
        else if (opcode == OP_SW) w_next = S_MEMWR;
        else                      w_next = S_ILLEGAL;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        memRead = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        w_retire = 1'b1;
        w_next   = halt_req ? S_HALT : S_FETCH;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        memWrite = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = halt_req ? S_HALT : S_FETCH;
        end
      end
      S_EXEC: begin
        aluOp  = 2'b10;
        w_next = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
        w_retire = 1'b1;
        w_next   = halt_req ? S_HALT : S_FETCH;
      end
      S_BRANCH: begin
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        w_retire    = 1'b1;
        w_next      = halt_req ? S_HALT : S_FETCH;
      end
      S_JUMP: begin
        pcWrite  = 1'b1;
        pcSource = 2'b11;
        w_retire = 1'b1;
        w_next   = halt_req ? S_HALT : S_FETCH;
      end
      S_ADDIEX: begin
        aluSrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        regWrite = 1'b1;
        w_retire = 1'b1;
        w_next   = halt_req ? S_HALT : S_FETCH;
      end
      S_ILLEGAL: begin
        illegal_op = 1'b1;
        w_next     = halt_req ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (!halt_req) w_next = S_FETCH;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: the stimulus pushes the
// hand-computed expected state/strobes/count per cycle, a monitor pops and
// compares on each falling edge. A second instance with a 4-bit counter
// checks the wrap.
module tb_multicycle_sequencer;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BAD  = 6'b111111;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] opcode;
  logic mem_ready, halt_req;

  logic pcWriteCond, pcWrite, IorD, memRead, memWrite, memToReg, irWrite;
  logic [1:0] pcSource, aluOp, aluSrcB;
  logic aluSrcA, regWrite, regDst, illegal_op, halted;
  logic [3:0] state;
  logic [31:0] retired;

  logic s_pwc, s_pw, s_iord, s_mrd, s_mwr, s_m2r, s_irw, s_asa, s_rw, s_rd, s_ill, s_hlt;
  logic [1:0] s_psrc, s_aop, s_asb;
  logic [3:0] s_state;
  logic [3:0] s_retired;

  multicycle_sequencer #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .halt_req(halt_req),
    .pcWriteCond(pcWriteCond), .pcWrite(pcWrite), .IorD(IorD), .memRead(memRead),
    .memWrite(memWrite), .memToReg(memToReg), .irWrite(irWrite), .pcSource(pcSource),
    .aluOp(aluOp), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .regWrite(regWrite),
    .regDst(regDst), .illegal_op(illegal_op), .halted(halted), .state(state),
    .retired(retired)
  );

  multicycle_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .halt_req(halt_req),
    .pcWriteCond(s_pwc), .pcWrite(s_pw), .IorD(s_iord), .memRead(s_mrd),
    .memWrite(s_mwr), .memToReg(s_m2r), .irWrite(s_irw), .pcSource(s_psrc),
    .aluOp(s_aop), .aluSrcA(s_asa), .aluSrcB(s_asb), .regWrite(s_rw),
    .regDst(s_rd), .illegal_op(s_ill), .halted(s_hlt), .state(s_state),
    .retired(s_retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [17:0] ctrl;
    logic [31:0] ret;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Expected control word for a state, straight from the per-state strobe list
  function automatic logic [17:0] exp_ctrl(input logic [3:0] s, input logic mr);
    logic pwc, pw, iord, mrd, mwr, m2r, irw, asa, rw, rd, ill, hlt;
    logic [1:0] psrc, aop, asb;
    {pwc, pw, iord, mrd, mwr, m2r, irw, asa, rw, rd, ill, hlt} = '0;
    psrc = 2'b00; aop = 2'b00; asb = 2'b00;
    case (s)
      4'd1:  begin mrd = 1; asa = 1; asb = 2'b01; irw = mr; pw = mr; end
      4'd2:  begin asa = 1; asb = 2'b11; end
      4'd3:  begin asb = 2'b10; end
      4'd4:  begin iord = 1; mrd = 1; end
      4'd5:  begin rw = 1; m2r = 1; end
      4'd6:  begin iord = 1; mwr = 1; end
      4'd7:  begin aop = 2'b10; end
      4'd8:  begin rw = 1; rd = 1; end
      4'd9:  begin aop = 2'b01; pwc = 1; psrc = 2'b01; end
      4'd10: begin pw = 1; psrc = 2'b11; end
      4'd11: begin asb = 2'b10; end
      4'd12: begin rw = 1; end
      4'd13: begin ill = 1; end
      4'd14: begin hlt = 1; end
      default: ;
    endcase
    return {pwc, pw, iord, mrd, mwr, m2r, irw, psrc, aop, asa, asb, rw, rd, ill, hlt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: each falling edge, pop one expected cycle and compare both instances
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("ctrl", 32'({pcWriteCond, pcWrite, IorD, memRead, memWrite, memToReg, irWrite,
                       pcSource, aluOp, aluSrcA, aluSrcB, regWrite, regDst, illegal_op,
                       halted}), 32'(e.ctrl));
      chk("retired", retired, e.ret);
      chk("retired_w4", 32'(s_retired), 32'(e.ret[3:0]));
    end
  end

  // Drive one cycle of inputs, queue its expected response, advance to next cycle
  task automatic cyc(input logic [5:0] op, input logic mr, input logic hr,
                     input logic [3:0] st, input logic [31:0] ret);
    exp_t e;
    opcode = op; mem_ready = mr; halt_req = hr;
    e.st = st; e.ctrl = exp_ctrl(st, mr); e.ret = ret;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    opcode = 6'd0; mem_ready = 1'b1; halt_req = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(RT, 1, 0, 4'd0, 0);           // in reset
    rst_n = 1'b1;
    cyc(RT, 1, 0, 4'd0, 0);           // IDLE
    cyc(RT, 1, 0, 4'd1, 0);           // FETCH ready
    // lw with three wait cycles
    cyc(LW, 1, 0, 4'd2, 0);
    cyc(LW, 1, 0, 4'd3, 0);
    cyc(LW, 0, 0, 4'd4, 0);
    cyc(LW, 0, 0, 4'd4, 0);
    cyc(LW, 0, 0, 4'd4, 0);
    cyc(LW, 1, 0, 4'd4, 0);
    cyc(LW, 0, 0, 4'd5, 0);
    // R-type, with one fetch wait first
    cyc(RT, 0, 0, 4'd1, 1);
    cyc(RT, 1, 0, 4'd1, 1);
    cyc(RT, 1, 0, 4'd2, 1);
    cyc(RT, 1, 0, 4'd7, 1);
    cyc(RT, 1, 0, 4'd8, 1);
    // beq
    cyc(BEQ, 1, 0, 4'd1, 2);
    cyc(BEQ, 1, 0, 4'd2, 2);
    cyc(BEQ, 1, 0, 4'd9, 2);
    // j
    cyc(JMP, 1, 0, 4'd1, 3);
    cyc(JMP, 1, 0, 4'd2, 3);
    cyc(JMP, 1, 0, 4'd10, 3);
    // addi
    cyc(ADDI, 1, 0, 4'd1, 4);
    cyc(ADDI, 1, 0, 4'd2, 4);
    cyc(ADDI, 1, 0, 4'd11, 4);
    cyc(ADDI, 1, 0, 4'd12, 4);
    // illegal opcode, not counted
    cyc(BAD, 1, 0, 4'd1, 5);
    cyc(BAD, 1, 0, 4'd2, 5);
    cyc(BAD, 1, 0, 4'd13, 5);
    // sw with one wait cycle
    cyc(SW, 1, 0, 4'd1, 5);
    cyc(SW, 1, 0, 4'd2, 5);
    cyc(SW, 1, 0, 4'd3, 5);
    cyc(SW, 0, 0, 4'd6, 5);
    cyc(SW, 1, 0, 4'd6, 5);
    // halt raised during MEMRD: lw completes, then HALT
    cyc(LW, 1, 0, 4'd1, 6);
    cyc(LW, 1, 0, 4'd2, 6);
    cyc(LW, 1, 0, 4'd3, 6);
    cyc(LW, 0, 1, 4'd4, 6);
    cyc(LW, 1, 1, 4'd4, 6);
    cyc(LW, 0, 1, 4'd5, 6);
    cyc(LW, 0, 1, 4'd14, 7);
    cyc(LW, 0, 0, 4'd14, 7);
    cyc(SW, 1, 0, 4'd1, 7);
    // sw stalled in MEMWR, then reset mid-access
    cyc(SW, 1, 0, 4'd2, 7);
    cyc(SW, 1, 0, 4'd3, 7);
    cyc(SW, 0, 0, 4'd6, 7);
    rst_n = 1'b0;
    cyc(SW, 0, 0, 4'd0, 0);
    cyc(SW, 0, 0, 4'd0, 0);
    rst_n = 1'b1;
    // halt straight from IDLE
    cyc(JMP, 1, 1, 4'd0, 0);
    cyc(JMP, 1, 0, 4'd14, 0);
    // 17 jumps: the 4-bit counter wraps 15 -> 0
    for (int i = 0; i < 17; i++) begin
      cyc(JMP, 1, 0, 4'd1, 32'(i));
      cyc(JMP, 1, 0, 4'd2, 32'(i));
      cyc(JMP, 1, 0, 4'd10, 32'(i));
    end
    cyc(JMP, 0, 0, 4'd1, 17);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Moore/Mealy control FSM that sequences the multicycle MIPS datapath: fetch, decode, execute, memory and writeback steps.
- Drives every datapath control strobe: PC write, IorD, memory read/write, IR write, ALU source and op selects, register-file write controls.
- Adds a memory-ready handshake for variable-latency memory, a halt request honoured at instruction boundaries, an illegal-opcode flag and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter; wraps modulo 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instructionRegister[31:26]
- mem_ready  in  1  memory completes the current read/write this cycle
- halt_req  in  1  request to stop at the next instruction boundary
- pcWriteCond  out  1  PC write if ALU zero
- pcWrite  out  1  unconditional PC write
- IorD  out  1  memory address select: 0 = PC, 1 = aluOut
- memRead  out  1  memory read strobe
- memWrite  out  1  memory write strobe
- memToReg  out  1  register write data: 1 = MDR, 0 = aluOut
- irWrite  out  1  instruction register load
- pcSource  out  2  00 = ALU result, 01 = aluOut, 11 = jump target
- aluOp  out  2  00 = add, 01 = subtract, 10 = use funct
- aluSrcA  out  1  1 = PC, 0 = register A
- aluSrcB  out  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- regWrite  out  1  register-file write enable
- regDst  out  1  1 = rd, 0 = rt
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- halted  out  1  high while in HALT
- state  out  4  current state encoding (debug)
- retired  out  CNT_W  count of completed instructions

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RTYPEWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12, ILLEGAL=13, HALT=14. Codes 15 and above go to IDLE.
- Reset (asynchronous, rst_n=0): state=IDLE, retired=0. All outputs are 0 in IDLE.
- Every output not listed for a state is 0.
- IDLE: next state is HALT if halt_req=1, otherwise FETCH.
- FETCH: memRead=1, IorD=0, aluSrcA=1, aluSrcB=01, aluOp=00, pcSource=00.
  - irWrite and pcWrite are asserted only in the cycle mem_ready=1 (Mealy).
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE: aluSrcA=1, aluSrcB=11, aluOp=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> ADDIEX
  - any other opcode -> ILLEGAL
- MEMADR: aluSrcA=0, aluSrcB=10, aluOp=00. Goes to MEMRD for lw, MEMWR for sw (opcode is still held in the IR).
- MEMRD: IorD=1, memRead=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: regWrite=1, memToReg=1, regDst=0.
- MEMWR: IorD=1, memWrite=1. Waits for mem_ready; the write completes in the mem_ready cycle.
- EXEC: aluSrcA=0, aluSrcB=00, aluOp=10, then RTYPEWB.
- RTYPEWB: regWrite=1, regDst=1, memToReg=0.
- BRANCH: aluSrcA=0, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01.
- JUMP: pcWrite=1, pcSource=11.
- ADDIEX: aluSrcA=0, aluSrcB=10, aluOp=00, then ADDIWB.
- ADDIWB: regWrite=1, regDst=0, memToReg=0.
- ILLEGAL: illegal_op=1 for exactly one cycle. No register, memory or PC write; not counted in retired.
- Boundary states are MEMWB, RTYPEWB, BRANCH, JUMP, ADDIWB, ILLEGAL, and MEMWR when mem_ready=1.
  - Each boundary state's next state is HALT if halt_req=1, otherwise FETCH.
  - On leaving a boundary state, retired increments by 1 (except ILLEGAL) and wraps to 0 after all-ones.
- HALT: halted=1, all strobes 0. Leaves to FETCH in the first cycle halt_req=0.
- halt_req never interrupts FETCH, DECODE, MEMADR, MEMRD, MEMWR or EXEC; an outstanding memory access always completes first.
- Memory strobes (memRead or memWrite) stay stable and continuously asserted until mem_ready is seen.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- Reset mid-operation: immediate return to IDLE with all strobes 0 and retired=0, regardless of any pending access.

Test Plan:
- Reset release with halt_req=0, mem_ready=1 -> IDLE for 1 cycle, FETCH asserts memRead/irWrite/pcWrite, then DECODE; state sequence 0,1,2.
- lw (opcode 100011) with mem_ready low 3 cycles in MEMRD -> state sequence 1,2,3,4,4,4,4,5,1; regWrite=1 and memToReg=1 only in state 5; retired 0->1.
- R-type, beq, j, addi back-to-back with mem_ready=1 -> cycle counts 4,3,3,4; beq gives pcWriteCond=1 with pcSource=01; j gives pcWrite=1 with pcSource=11; retired=4.
- opcode 111111 -> ILLEGAL (state 13) for 1 cycle, illegal_op pulses once, no regWrite/memWrite/pcWrite; retired unchanged.
- halt_req raised during MEMRD of lw -> lw completes through MEMWB, state 14, halted=1; drop halt_req -> FETCH on the next cycle.
- rst_n pulled low during MEMWR with mem_ready=0 -> memWrite drops to 0 immediately, state=0, retired=0.
- CNT_W=4: retire 16 instructions -> retired wraps from 15 to 0.
